// File: rtl/ntt_ctrl_pkg.sv
// Shared types and sizing helpers for the NTT batch stream controller.
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // One spare counter bit so a full batch of 2^ADDR_W counts without wrapping.
  localparam int unsigned CNT_EXTRA_W = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned addr_width(input int unsigned logn, input int unsigned logp);
    return logn + logp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned addr_w);
    return addr_w + CNT_EXTRA_W;
  endfunction

endpackage

// File: rtl/bitreverse.sv
// Reverses the bit order of a W-bit index.
module bitreverse #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(W); i++) begin
      dout[i] = din[int'(W) - 1 - i];
    end
  end

endmodule

// File: rtl/ntt_batch_stream_ctrl.sv
// Streams 1..2^LOGP polynomials from a coefficient BRAM through an external
// SDF NTT core and writes results back in natural or bit-reversed order.
module ntt_batch_stream_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned LOGN        = 8,
  parameter int unsigned LOGQ        = 32,
  parameter int unsigned LOGP        = 2,
  parameter int unsigned START_DELAY = 10,
  parameter int unsigned BITREV_OUT  = 1,
  parameter int unsigned ADDR_W      = addr_width(LOGN, LOGP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              intt_in,
  input  logic [LOGP-1:0]   npoly_m1,
  output logic              busy,
  output logic              done,
  output logic              intt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [LOGQ-1:0]   rd_data,
  output logic              core_clr,
  output logic              core_start,
  output logic [LOGQ-1:0]   core_in,
  input  logic              core_valid,
  input  logic [LOGQ-1:0]   core_out,
  output logic              wea,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LOGQ-1:0]   wr_data
);

  localparam int unsigned CNT_W = cnt_width(ADDR_W);
  localparam int unsigned DLY_W = clog2(START_DELAY) + 1;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] total_q, rd_cnt, wr_cnt;
  logic [DLY_W-1:0] dly_cnt;
  logic             accept, last_rd, last_wr, wr_fire;
  logic             busy_d, done_d, rd_en_d, core_clr_d, core_start_d;

  assign accept  = (state == IDLE) && start;
  assign last_rd = (state == STREAM) && (rd_cnt == total_q - CNT_W'(1));
  // Writes are gated by reset so an aborted batch never lands a partial write.
  assign wr_fire = busy && core_valid && (wr_cnt < total_q) && !rst;
  assign last_wr = (wr_cnt == total_q) || (wr_fire && (wr_cnt == total_q - CNT_W'(1)));

  assign wea     = wr_fire;
  assign core_in = rd_data;
  assign wr_data = core_out;
  assign rd_addr = rd_cnt[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME:   if (dly_cnt == DLY_W'(START_DELAY - 1)) state_nxt = STREAM;
      STREAM:  if (last_rd) state_nxt = DRAIN;
      DRAIN:   if (last_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode on the upcoming state so the strobes come out of flops
  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    rd_en_d      = 1'b0;
    core_clr_d   = 1'b0;
    core_start_d = 1'b0;
    busy_d       = (state_nxt != IDLE);
    rd_en_d      = (state_nxt == STREAM);
    core_start_d = (state_nxt == STREAM) || (state_nxt == DRAIN);
    core_clr_d   = (state == IDLE) && (state_nxt == PRIME);
    done_d       = (state == DRAIN) && (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      core_clr   <= 1'b0;
      core_start <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      rd_en      <= rd_en_d;
      core_clr   <= core_clr_d;
      core_start <= core_start_d;
    end
  end

  // Batch parameters and the delay/read/write counters
  always_ff @(posedge clk) begin
    if (rst) begin
      intt    <= 1'b0;
      total_q <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      dly_cnt <= '0;
    end else if (accept) begin
      intt    <= intt_in;
      total_q <= (CNT_W'(npoly_m1) + CNT_W'(1)) << LOGN;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      dly_cnt <= '0;
    end else begin
      if (state == PRIME)  dly_cnt <= dly_cnt + DLY_W'(1);
      if (state == STREAM) rd_cnt  <= rd_cnt + CNT_W'(1);
      if (wr_fire)         wr_cnt  <= wr_cnt + CNT_W'(1);
    end
  end

  // Bit reversal stays inside the low LOGN bits so the poly field is untouched.
  generate
    if (BITREV_OUT != 0) begin : g_bitrev
      logic [LOGN-1:0] idx_rev;
      bitreverse #(.W(LOGN)) u_bitreverse (
        .din  (wr_cnt[LOGN-1:0]),
        .dout (idx_rev)
      );
      assign wr_addr = {wr_cnt[ADDR_W-1:LOGN], idx_rev};
    end else begin : g_natural
      assign wr_addr = wr_cnt[ADDR_W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_ntt_batch_stream_ctrl.sv
// Directed-plus-random bench for ntt_batch_stream_ctrl with a queue-based core
// model and a batch-level reference model; checks bit-reversed and natural DUTs.
module tb_ntt_batch_stream_ctrl;

  localparam int LOGN = 3;
  localparam int LOGP = 2;
  localparam int SD   = 10;
  localparam int N    = 8;
  localparam int LAT  = 20;
  localparam int LIM  = 3000;
  localparam logic [31:0] KEY = 32'h5A3C_96E1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } core_item_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        intt;
    logic        rd_en;
    logic        core_clr;
    logic        core_start;
    logic        wea;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] core_in;
    logic [31:0] wr_data;
  } obs_t;

  logic        clk, rst, start, intt_in, core_valid;
  logic [1:0]  npoly_m1;
  logic [31:0] rd_data, core_out;

  logic        busy_b, done_b, intt_b, rd_en_b, core_clr_b, core_start_b, wea_b;
  logic [4:0]  rd_addr_b, wr_addr_b;
  logic [31:0] core_in_b, wr_data_b;
  logic        busy_n, done_n, intt_n, rd_en_n, core_clr_n, core_start_n, wea_n;
  logic [4:0]  rd_addr_n, wr_addr_n;
  logic [31:0] core_in_n, wr_data_n;

  ntt_batch_stream_ctrl #(
    .LOGN(LOGN), .LOGQ(32), .LOGP(LOGP), .START_DELAY(SD), .BITREV_OUT(1)
  ) u_br (
    .clk(clk), .rst(rst), .start(start), .intt_in(intt_in), .npoly_m1(npoly_m1),
    .busy(busy_b), .done(done_b), .intt(intt_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data), .core_clr(core_clr_b), .core_start(core_start_b), .core_in(core_in_b),
    .core_valid(core_valid), .core_out(core_out), .wea(wea_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b)
  );

  ntt_batch_stream_ctrl #(
    .LOGN(LOGN), .LOGQ(32), .LOGP(LOGP), .START_DELAY(SD), .BITREV_OUT(0)
  ) u_nat (
    .clk(clk), .rst(rst), .start(start), .intt_in(intt_in), .npoly_m1(npoly_m1),
    .busy(busy_n), .done(done_n), .intt(intt_n), .rd_en(rd_en_n), .rd_addr(rd_addr_n),
    .rd_data(rd_data), .core_clr(core_clr_n), .core_start(core_start_n), .core_in(core_in_n),
    .core_valid(core_valid), .core_out(core_out), .wea(wea_n), .wr_addr(wr_addr_n),
    .wr_data(wr_data_n)
  );

  obs_t ob, on;
  assign ob = {busy_b, done_b, intt_b, rd_en_b, core_clr_b, core_start_b, wea_b,
               rd_addr_b, wr_addr_b, core_in_b, wr_data_b};
  assign on = {busy_n, done_n, intt_n, rd_en_n, core_clr_n, core_start_n, wea_n,
               rd_addr_n, wr_addr_n, core_in_n, wr_data_n};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Stimulus knobs
  bit rst_r, start_r, intt_r, cv_force, stall_en;
  int np_r;

  // Reference model state
  logic [31:0] mem [32];
  core_item_t  q [$];
  bit m_busy, m_done, m_intt, m_rst_prev;
  int t_acc, total, wr_seen, obs_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int addr_of(input int k, input bit brv);
    int idx, r;
    idx = k % N;
    r = 0;
    if (!brv) return k;
    for (int b = 0; b < LOGN; b++) begin
      if ((idx & (1 << b)) != 0) r = r | (1 << (LOGN - 1 - b));
    end
    return (k / N) * N + r;
  endfunction

  task automatic check_dut(input string nm, input obs_t o, input bit brv, input bit e_rd,
                           input bit e_clr, input bit e_start, input bit e_wea);
    chk({nm, ".busy"},       32'(o.busy),       32'(m_busy));
    chk({nm, ".done"},       32'(o.done),       32'(m_done));
    chk({nm, ".intt"},       32'(o.intt),       32'(m_intt));
    chk({nm, ".rd_en"},      32'(o.rd_en),      32'(e_rd));
    chk({nm, ".core_clr"},   32'(o.core_clr),   32'(e_clr));
    chk({nm, ".core_start"}, 32'(o.core_start), 32'(e_start));
    chk({nm, ".wea"},        32'(o.wea),        32'(e_wea));
    if (e_rd) begin
      chk({nm, ".rd_addr"}, 32'(o.rd_addr), 32'(cyc - (t_acc + 1 + SD)));
      chk({nm, ".core_in"}, o.core_in, rd_data);
    end
    if (e_wea) begin
      chk({nm, ".wr_addr"}, 32'(o.wr_addr), 32'(addr_of(wr_seen, brv)));
      chk({nm, ".wr_data"}, o.wr_data, mem[wr_seen] ^ KEY);
    end
    if (m_rst_prev) begin
      chk({nm, ".rd_addr_rst"}, 32'(o.rd_addr), 32'd0);
      chk({nm, ".wr_addr_rst"}, 32'(o.wr_addr), 32'd0);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check settled outputs, advance the model.
  task automatic step();
    bit cv_q, e_rd, e_clr, e_start, e_wea, old_busy;
    core_item_t it;
    @(negedge clk);
    rst      = rst_r;
    start    = start_r;
    intt_in  = intt_r;
    npoly_m1 = 2'(np_r);
    rd_data  = mem[rd_addr_b];
    cv_q = (q.size() > 0) && (q[0].due <= cyc) && !(stall_en && ($urandom_range(0, 3) == 0));
    core_valid = cv_q | cv_force;
    core_out   = cv_q ? q[0].data : 32'h0;
    #1;
    e_rd    = m_busy && (cyc >= t_acc + 1 + SD) && (cyc <= t_acc + SD + total);
    e_clr   = m_busy && (cyc == t_acc + 1);
    e_start = m_busy && (cyc >= t_acc + 1 + SD);
    e_wea   = m_busy && core_valid && (wr_seen < total) && !rst;
    if (cyc > 0) begin
      check_dut("br",  ob, 1'b1, e_rd, e_clr, e_start, e_wea);
      check_dut("nat", on, 1'b0, e_rd, e_clr, e_start, e_wea);
    end
    old_busy = m_busy;
    if (rst) begin
      q.delete();
      m_busy = 0; m_done = 0; m_intt = 0; wr_seen = 0;
    end else begin
      if (rd_en_b === 1'b1) begin
        it.data = core_in_b ^ KEY;
        it.due  = cyc + LAT;
        q.push_back(it);
        obs_rd++;
      end
      if (cv_q) void'(q.pop_front());
      m_done = 0;
      if (old_busy && e_wea) begin
        wr_seen++;
        if (wr_seen == total) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (!old_busy && start) begin
        m_busy = 1; t_acc = cyc; total = (np_r + 1) * N;
        wr_seen = 0; m_intt = intt_r; obs_rd = 0;
      end
    end
    m_rst_prev = rst;
    cyc++;
  endtask

  task automatic run_batch(input int np, input bit iv, input bit stall, input int mid_start,
                           input int abort_at, input int b2b);
    int rel, guard, b2b_left;
    np_r = np; intt_r = iv; stall_en = stall; start_r = 1;
    step();
    start_r = 0;
    rel = 0; guard = 0; b2b_left = b2b;
    while ((m_busy || m_done) && guard < LIM) begin
      rel++; guard++;
      start_r = (rel == mid_start);
      if (b2b_left > 0 && m_done) begin
        start_r = 1;
        b2b_left--;
      end
      intt_r = iv ^ ((rel >= 5) && (rel < 20));
      rst_r  = (abort_at > 0) && m_busy && (wr_seen == abort_at);
      step();
    end
    rst_r = 0; start_r = 0; intt_r = iv;
    chk("timeout", 32'(guard >= LIM), 32'd0);
    if (abort_at == 0) chk("rd_count", 32'(obs_rd), 32'(total));
    cv_force = 1;
    repeat (3) step();
    cv_force = 0;
    repeat (2) step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    rst_r = 1; start_r = 0; intt_r = 0; cv_force = 0; stall_en = 0; np_r = 0;
    m_busy = 0; m_done = 0; m_intt = 0; m_rst_prev = 0;
    t_acc = 0; total = 0; wr_seen = 0; obs_rd = 0;
    repeat (3) step();
    rst_r = 0;
    repeat (2) step();

    // Single polynomial, inverse mode toggled mid-batch, valid held after the end
    run_batch(0, 1'b1, 1'b0, 0, 0, 0);
    // Four polynomials with a stray start during STREAM
    run_batch(3, 1'b0, 1'b0, 14, 0, 0);
    // Back-to-back start on the done cycle
    run_batch(1, 1'b1, 1'b0, 0, 0, 1);
    // Reset in DRAIN after five writes, then a clean batch
    run_batch(0, 1'b0, 1'b0, 0, 5, 0);
    run_batch(0, 1'b1, 1'b0, 0, 0, 0);
    // Random batch lengths, modes and core stalls
    for (int b = 0; b < 4; b++) begin
      run_batch(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_batch_stream_ctrl.md
# ntt_batch_stream_ctrl

Batch controller for the streaming SDF NTT core. It runs one to 2^LOGP polynomials of 2^LOGN coefficients back-to-back through an externally instantiated SDF core. It reads from a coefficient BRAM and writes results to a result BRAM in natural or bit-reversed order. It adds a start/busy/done handshake, runtime batch length and per-batch forward/inverse mode, and a core clear pulse so batches can be re-run without a global reset.

## Interface
Parameters:
- LOGN, 8, log2 coefficients per polynomial (N = 2^LOGN)
- LOGQ, 32, coefficient width
- LOGP, 2, log2 maximum polynomials per batch
- START_DELAY, 10, cycles from start acceptance to first read (BRAM/twiddle prime time), must be ≥ 1
- BITREV_OUT, 1, 1 writes index bit-reversed within each polynomial, 0 writes natural order
- ADDR_W, LOGN+LOGP, address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  batch request pulse; sampled only in IDLE
- intt_in  in  1  mode for the batch, latched at acceptance
- npoly_m1  in  LOGP  number of polynomials minus one, latched at acceptance
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse after the last write
- intt  out  1  latched mode, driven to the core
- rd_en  out  1  coefficient BRAM read strobe
- rd_addr  out  ADDR_W  {poly, idx}
- rd_data  in  LOGQ  BRAM read data
- core_clr  out  1  one-cycle core counter clear
- core_start  out  1  core run level
- core_in  out  LOGQ  equals rd_data, combinational pass-through
- core_valid  in  1  core output valid (the core's finish level)
- core_out  in  LOGQ  core output
- wea  out  1  result BRAM write enable
- wr_addr  out  ADDR_W  {poly, idx or bitrev(idx)}
- wr_data  out  LOGQ  equals core_out

## Operation
- States: IDLE → PRIME → STREAM → DRAIN → IDLE.
- IDLE: start=1 latches intt_in and npoly_m1 into TOTAL = (npoly_m1+1)·N, then goes to PRIME. core_clr pulses in the first PRIME cycle.
- PRIME: a delay counter runs START_DELAY cycles, then the block enters STREAM.
- STREAM: rd_en=1 and core_start=1. The read counter starts at 0 and increments every cycle. After TOTAL reads the block enters DRAIN with rd_en=0.
- core_start stays 1 through STREAM and DRAIN, and is 0 in IDLE and PRIME.
- Writes: in any busy state, core_valid=1 with write count < TOTAL gives wea=1. wr_addr comes from the write counter, which then increments. core_valid is ignored once count = TOTAL or when not busy.
- Leaving DRAIN: when the write count reaches TOTAL, the block enters IDLE, pulses done and drops busy.
- The poly field is the upper LOGP bits of the counter. Bit reversal applies only to the low LOGN bits, so polynomial boundaries are never crossed.
- Counters are ADDR_W+1 bits wide, so TOTAL = 2^ADDR_W is representable with no wrap.
- start while busy is ignored and has no queueing.

## Timing
- Reset values: busy, done, rd_en, core_clr, core_start, wea and intt are 0. rd_addr and wr_addr are 0. The state goes to IDLE and all counters clear.
- start accepted at cycle t:
  - busy=1 from t+1
  - core_clr=1 at t+1
  - first rd_en and core_start at t+1+START_DELAY
  - last read at t+START_DELAY+TOTAL
- core_in follows rd_data with zero added latency. BRAM latency is absorbed by the core.
- Last write at cycle w gives done=1 and busy=0 at w+1. A new start is accepted from w+1 onward.
- If core_valid goes high during STREAM, reads and writes overlap. Both counters advance in the same cycle independently.
- rst in any state aborts immediately with the reset values above. No done pulse is issued and no partial write completes.

## Structure
- Shared package ntt_ctrl_pkg holds:
  - the state enum (IDLE, PRIME, STREAM, DRAIN)
  - a clog2/ADDR_W helper
  - the counter width constant
- One sub-module: the existing bitreverse, instantiated with width LOGN on the low write-counter bits.
- The SDF core stays outside this block.

## Test plan
- LOGN=3, LOGP=2, npoly_m1=0, START_DELAY=10, model core with 20-cycle latency, start at t=0 → core_clr at 1, rd_en on cycles 11–18 with rd_addr 0–7, wea ×8 with wr_addr 0,4,2,6,1,5,3,7, done one cycle after the 8th write.
- npoly_m1=3, BITREV_OUT=0 → 32 contiguous reads 0–31, writes 0–31 in order, exactly one done, busy high throughout.
- start pulsed again mid-STREAM → ignored, read count stays 8·(npoly_m1+1). A back-to-back start on the done cycle is accepted.
- rst asserted in DRAIN after 5 of 8 writes → next cycle all outputs 0, no done. A following start runs a full clean batch beginning with core_clr.
- intt_in=1 at start, then toggled during the batch → intt stays 1 until the next acceptance. core_valid held high after the final write → no extra wea.
